game_io_event_bridge: RTL and testbench



---
 rtl/game_io_event_bridge.sv | 148 ++++++++++++++
 tb/tb_game_io_event_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_io_event_bridge.sv
// game_io_event_bridge
//   Turns raw game-board inputs into the register-file event words and
//   one-cycle write strobes for r20 (button), r22 (frame), r24 (collision)
//   and r26 (live status).
//
// Ports
//   clock                 in   system clock
//   ctrl_reset            in   synchronous, active-high reset
//   button_raw            in   asynchronous jump button (synchronized + debounced)
//   pause_raw             in   asynchronous pause button (synchronized + debounced)
//   frame_tick            in   end-of-frame pulse, clock domain
//   collision_raw         in   renderer collision level, clock domain
//   r20                   out  {31'b0, button_level}
//   r22                   out  frame event counter
//   r24                   out  collision event counter
//   r26                   out  {29'b0, collision_raw_q, pause_state, button_level}
//   button_signal_reg     out  strobe: debounced button level changed
//   screen_signal_reg     out  strobe: frame divider wrapped (not paused)
//   collision_signal_reg  out  strobe: collision rising edge (not paused)
//   pause_signal_reg      out  strobe: debounced pause press toggled pause_state
//   pause_state           out  current pause flag
module game_io_event_bridge #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FRAME_DIV       = 1
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        button_raw,
  input  logic        pause_raw,
  input  logic        frame_tick,
  input  logic        collision_raw,
  output logic [31:0] r20,
  output logic [31:0] r22,
  output logic [31:0] r24,
  output logic [31:0] r26,
  output logic        button_signal_reg,
  output logic        screen_signal_reg,
  output logic        collision_signal_reg,
  output logic        pause_signal_reg,
  output logic        pause_state
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_MAX = DW'(FRAME_DIV - 1);

  // Channel 0 = jump button, channel 1 = pause button.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    lvl_q, lvl_d;
  logic [1:0]    flip;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  logic          pause_q, pause_d;
  logic [DW-1:0] div_q, div_d;
  logic [31:0]   r22_q, r22_d, r24_q, r24_d;
  logic          coll_q;
  logic          frame_ev, col_ev;
  logic          btn_stb_q, pause_stb_q, scr_stb_q, col_stb_q;

  assign raw = {pause_raw, button_raw};

  // Counter only reaches CNT_MAX after DEBOUNCE_CYCLES consecutive differing
  // samples; the flip happens on the following differing sample.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = '0;
      flip[i]  = 1'b0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          lvl_d[i] = ~lvl_q[i];
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Frame and collision gating use pause_q, i.e. the value before any toggle
  // landing in this same cycle.
  always_comb begin
    pause_d  = pause_q ^ (flip[1] & lvl_d[1]);
    frame_ev = 1'b0;
    div_d    = div_q;
    r22_d    = r22_q;
    if (frame_tick && !pause_q) begin
      if (div_q == DIV_MAX) begin
        div_d    = '0;
        frame_ev = 1'b1;
        r22_d    = r22_q + 32'd1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end
    col_ev = collision_raw & ~coll_q & ~pause_q;
    r24_d  = col_ev ? r24_q + 32'd1 : r24_q;
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      pause_q     <= 1'b0;
      div_q       <= '0;
      r22_q       <= '0;
      r24_q       <= '0;
      coll_q      <= 1'b0;
      btn_stb_q   <= 1'b0;
      pause_stb_q <= 1'b0;
      scr_stb_q   <= 1'b0;
      col_stb_q   <= 1'b0;
    end else begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      lvl_q       <= lvl_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      pause_q     <= pause_d;
      div_q       <= div_d;
      r22_q       <= r22_d;
      r24_q       <= r24_d;
      coll_q      <= collision_raw;
      btn_stb_q   <= flip[0];
      pause_stb_q <= flip[1] & lvl_d[1];
      scr_stb_q   <= frame_ev;
      col_stb_q   <= col_ev;
    end
  end

  // Outputs are direct views of flops.
  assign r20                  = {31'b0, lvl_q[0]};
  assign r22                  = r22_q;
  assign r24                  = r24_q;
  assign r26                  = {29'b0, coll_q, pause_q, lvl_q[0]};
  assign button_signal_reg    = btn_stb_q;
  assign screen_signal_reg    = scr_stb_q;
  assign collision_signal_reg = col_stb_q;
  assign pause_signal_reg     = pause_stb_q;
  assign pause_state          = pause_q;

endmodule

// File: tb/tb_game_io_event_bridge.sv
module tb_game_io_event_bridge;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        button_raw, pause_raw, frame_tick, collision_raw;
  logic [31:0] r20, r22, r24, r26;
  logic        button_signal_reg, screen_signal_reg, collision_signal_reg;
  logic        pause_signal_reg, pause_state;

  int n_assert = 0;
  int n_fail   = 0;
  int btn_cnt  = 0;
  int scr_cnt  = 0;
  int col_cnt  = 0;
  int pau_cnt  = 0;
  int base;

  game_io_event_bridge #(
    .DEBOUNCE_CYCLES(4),
    .FRAME_DIV      (3)
  ) dut (
    .clock               (clock),
    .ctrl_reset          (ctrl_reset),
    .button_raw          (button_raw),
    .pause_raw           (pause_raw),
    .frame_tick          (frame_tick),
    .collision_raw       (collision_raw),
    .r20                 (r20),
    .r22                 (r22),
    .r24                 (r24),
    .r26                 (r26),
    .button_signal_reg   (button_signal_reg),
    .screen_signal_reg   (screen_signal_reg),
    .collision_signal_reg(collision_signal_reg),
    .pause_signal_reg    (pause_signal_reg),
    .pause_state         (pause_state)
  );

  always #5 clock = ~clock;

  // Strobe tallies, sampled mid-cycle.
  always @(negedge clock) begin
    if (button_signal_reg)    btn_cnt++;
    if (screen_signal_reg)    scr_cnt++;
    if (collision_signal_reg) col_cnt++;
    if (pause_signal_reg)     pau_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold pause_raw high until the debounced press lands (7 cycles), then release.
  task automatic pause_press(input logic exp_state);
    pause_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("pause_strobe", 32'(pause_signal_reg), 32'(k == 7));
      if (k == 7) check("pause_state_toggle", 32'(pause_state), 32'(exp_state));
    end
    pause_raw = 1'b0;
    tick(8);
    check("pause_release_no_effect", 32'(pause_state), 32'(exp_state));
  endtask

  initial begin
    ctrl_reset    = 1'b1;
    button_raw    = 1'b0;
    pause_raw     = 1'b0;
    frame_tick    = 1'b0;
    collision_raw = 1'b0;
    tick(2);

    // Reset state
    check("rst_r20", r20, 32'h0);
    check("rst_r22", r22, 32'h0);
    check("rst_r24", r24, 32'h0);
    check("rst_r26", r26, 32'h0);
    check("rst_strobes", 32'({button_signal_reg, screen_signal_reg,
                              collision_signal_reg, pause_signal_reg}), 32'h0);
    check("rst_pause", 32'(pause_state), 32'h0);
    ctrl_reset = 1'b0;
    tick(2);

    // Debounce accept: strobe 7 cycles after the edge, one pulse only
    button_raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("btn_rise_strobe", 32'(button_signal_reg), 32'(k == 7));
      if (k == 7) begin
        check("btn_rise_r20", r20, 32'h1);
        check("btn_rise_r26", r26, 32'h1);
      end
    end
    button_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("btn_fall_strobe", 32'(button_signal_reg), 32'(k == 7));
      if (k == 7) check("btn_fall_r20", r20, 32'h0);
    end

    // Bounce reject: 3-cycle runs never reach 4 stable samples
    base = btn_cnt;
    for (int t = 0; t < 10; t++) begin
      button_raw = ~button_raw;
      tick(3);
    end
    tick(8);
    check("bounce_no_strobe", 32'(btn_cnt - base), 32'h0);
    check("bounce_r20", r20, 32'h0);

    // Frame divider by 3: events on ticks 3 and 6
    base = scr_cnt;
    for (int n = 1; n <= 7; n++) begin
      frame_tick = 1'b1;
      tick(1);
      check("frame_strobe", 32'(screen_signal_reg), 32'(n % 3 == 0));
      frame_tick = 1'b0;
      tick(1);
    end
    check("frame_r22", r22, 32'h2);
    check("frame_count", 32'(scr_cnt - base), 32'h2);

    // Paused: ticks ignored
    pause_press(1'b1);
    base = scr_cnt;
    for (int n = 0; n < 5; n++) begin
      frame_tick = 1'b1;
      tick(1);
      check("paused_frame_strobe", 32'(screen_signal_reg), 32'h0);
      frame_tick = 1'b0;
      tick(1);
    end
    check("paused_r22", r22, 32'h2);
    check("paused_frame_count", 32'(scr_cnt - base), 32'h0);

    // Collision edges, unpaused
    pause_press(1'b0);
    base = col_cnt;
    collision_raw = 1'b1;
    tick(1);
    check("col1_strobe", 32'(collision_signal_reg), 32'h1);
    check("col1_r24", r24, 32'h1);
    tick(19);
    check("col_hold_r26", r26, 32'h4);
    collision_raw = 1'b0;
    tick(3);
    collision_raw = 1'b1;
    tick(1);
    check("col2_strobe", 32'(collision_signal_reg), 32'h1);
    check("col2_r24", r24, 32'h2);
    tick(3);
    collision_raw = 1'b0;
    tick(2);
    check("col_count", 32'(col_cnt - base), 32'h2);

    // Collision edges, paused
    pause_press(1'b1);
    base = col_cnt;
    collision_raw = 1'b1;
    tick(5);
    collision_raw = 1'b0;
    tick(2);
    collision_raw = 1'b1;
    tick(3);
    collision_raw = 1'b0;
    tick(2);
    check("paused_col_r24", r24, 32'h2);
    check("paused_col_count", 32'(col_cnt - base), 32'h0);

    // Simultaneous: divider sits at 1, one more tick brings it to 2
    pause_press(1'b0);
    frame_tick = 1'b1;
    tick(1);
    check("pre_sim_frame_strobe", 32'(screen_signal_reg), 32'h0);
    frame_tick = 1'b0;
    tick(1);
    pause_raw = 1'b1;
    tick(6);
    frame_tick    = 1'b1;
    collision_raw = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    check("sim_screen", 32'(screen_signal_reg), 32'h1);
    check("sim_collision", 32'(collision_signal_reg), 32'h1);
    check("sim_pause_strobe", 32'(pause_signal_reg), 32'h1);
    check("sim_pause_state", 32'(pause_state), 32'h1);
    check("sim_r22", r22, 32'h3);
    check("sim_r24", r24, 32'h3);
    check("sim_r26", r26, 32'h6);

    // Reset mid-debounce
    pause_raw     = 1'b0;
    collision_raw = 1'b0;
    tick(8);
    button_raw = 1'b1;
    tick(4);
    ctrl_reset = 1'b1;
    tick(1);
    ctrl_reset = 1'b0;
    check("mid_rst_r20", r20, 32'h0);
    check("mid_rst_r22", r22, 32'h0);
    check("mid_rst_r24", r24, 32'h0);
    check("mid_rst_r26", r26, 32'h0);
    check("mid_rst_strobes", 32'({button_signal_reg, screen_signal_reg,
                                  collision_signal_reg, pause_signal_reg}), 32'h0);
    check("mid_rst_pause", 32'(pause_state), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("post_rst_btn_strobe", 32'(button_signal_reg), 32'(k == 7));
      if (k == 7) check("post_rst_r20", r20, 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
